// File: rtl/ma_pkg.sv
// Shared defaults and sample/sum types for the moving-average filter.
package ma_pkg;

  localparam int unsigned DEF_SAMPLE_W = 8;
  localparam int unsigned DEF_LOG2_N   = 2;
  localparam int unsigned DEF_N        = 1 << DEF_LOG2_N;

  typedef logic signed [DEF_SAMPLE_W-1:0]            sample_t;
  typedef logic signed [DEF_SAMPLE_W+DEF_LOG2_N-1:0] sum_t;

endpackage

// File: rtl/ma_window.sv
// N-deep signed sample shift register; taps[0] is the newest sample.
module ma_window
  import ma_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned DEPTH    = DEF_N
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SAMPLE_W-1:0]                din,
  output logic [DEPTH-1:0][SAMPLE_W-1:0]     taps
);

  // Shift a new sample in every edge; reset clears the whole window at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/moving_average2_top_entity.sv
// Signed moving average over the last 2**LOG2_N samples, floor-rounded.
module moving_average2_top_entity
  import ma_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned LOG2_N   = DEF_LOG2_N
) (
  input  logic                       system1000,
  input  logic                       system1000_rstn,
  input  logic signed [SAMPLE_W-1:0] eta_i1,
  output logic signed [SAMPLE_W-1:0] topLet_o
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = SAMPLE_W + LOG2_N;

  logic [N-1:0][SAMPLE_W-1:0] taps;
  logic signed [SUM_W-1:0]    sum_c;
  logic signed [SUM_W-1:0]    avg_c;

  ma_window #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (N)
  ) u_window (
    .clk   (system1000),
    .rst_n (system1000_rstn),
    .din   (eta_i1),
    .taps  (taps)
  );

  // Sum the window at full width so it cannot overflow, then divide by N with an arithmetic shift.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_c = sum_c + SUM_W'($signed(taps[i]));
    end
    avg_c    = sum_c >>> LOG2_N;
    topLet_o = avg_c[SAMPLE_W-1:0];
  end

endmodule

// File: tb/tb_moving_average2_top_entity.sv
// Scoreboard bench: driver pushes model expectations, monitor checks after each edge.
module tb_moving_average2_top_entity;

  localparam int N = 4;

  logic              clk;
  logic              rstn;
  logic signed [7:0] eta;
  logic signed [7:0] out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int win[$];

  moving_average2_top_entity #(
    .SAMPLE_W (8),
    .LOG2_N   (2)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .eta_i1          (eta),
    .topLet_o        (out)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Floor of sum/N written as plain integer arithmetic.
  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    win.delete();
    for (int i = 0; i < N; i++) win.push_back(0);
  endtask

  // Apply one sample ahead of the next edge and record what the mean must become.
  task automatic drive(input int x);
    int s;
    @(negedge clk);
    rstn = 1'b1;
    eta  = 8'(x);
    win.push_front(x);
    void'(win.pop_back());
    s = 0;
    foreach (win[i]) s += win[i];
    exp_q.push_back(floor_div(s, N));
  endtask

  // Monitor: one result per edge, sampled away from the edge.
  initial begin
    forever begin
      @(posedge clk);
      #100;
      if (exp_q.size() > 0) check("avg", int'(out), exp_q.pop_front());
    end
  end

  initial begin
    int v;
    rstn = 1'b0;
    eta  = 8'sd55;
    clear_model();
    #10;
    check("reset_async", int'(out), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #100;
      check("reset_hold", int'(out), 0);
    end

    for (int i = 0; i < 4; i++) drive(4);
    for (int i = 0; i < 4; i++) drive(0);
    for (int i = 0; i < 4; i++) drive(127);
    for (int i = 0; i < 4; i++) drive(0);
    for (int i = 0; i < 4; i++) drive(-128);
    for (int i = 0; i < 4; i++) drive(0);
    drive(-1);
    for (int i = 0; i < 4; i++) drive(0);
    for (int i = 0; i < 12; i++) drive((i % 2 == 0) ? 10 : -10);
    for (int i = 0; i < 4; i++) drive(100);

    // Mid-cycle reset must clear the output before the next edge.
    @(posedge clk);
    #200;
    rstn = 1'b0;
    eta  = 8'sd0;
    clear_model();
    #10;
    check("reset_mid", int'(out), 0);
    repeat (2) @(negedge clk);
    drive(8);

    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(0, 255)) - 128;
      if (i % 50 < 4) v = (i < 100) ? 127 : -128;
      drive(v);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #200;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moving_average2_top_entity.md
Name: moving_average2_top_entity

Overview:
- Streaming signed moving-average filter over the last N = 2^LOG2_N input samples.
- Takes one new sample on every clock edge, with no valid/ready handshake.
- The output is the arithmetic mean of the current window, rounded toward negative infinity.
- Top-level entity of the MovingAverage2 design; in simulation it is driven by a 1000-time-unit clock domain.

Parameters:
- SAMPLE_W, 8, width of the signed input and output samples.
- LOG2_N, 2, log2 of the window length (N = 4 by default); must be ≥ 1.

Ports:
- system1000  input  1  clock; all state updates on the rising edge.
- system1000_rstn  input  1  reset, asynchronous, active-low.
- eta_i1  input  SAMPLE_W  signed input sample, taken every cycle.
- topLet_o  output  SAMPLE_W  signed moving average of the last N samples.

Behaviour:
- State is N sample registers w[0..N-1], each SAMPLE_W signed; w[0] is the newest.
- Reset:
  - While system1000_rstn = 0, all w[i] = 0 immediately, without waiting for a clock edge.
  - Consequently topLet_o = 0 during reset.
  - Deassertion is honoured at the next rising edge.
- Each rising edge when not in reset:
  - w[0] <= eta_i1, and w[i] <= w[i-1] for i = 1..N-1.
  - The oldest sample is discarded.
- Output arithmetic:
  - sum = Σ w[i], computed signed at SAMPLE_W+LOG2_N bits, so it cannot overflow.
  - topLet_o = sum >>> LOG2_N (arithmetic shift), i.e. floor(sum/N).
  - The result always fits in SAMPLE_W bits; truncate to SAMPLE_W.
- Latency: topLet_o is combinational from the w registers, so a sample captured at edge k is reflected in topLet_o right after edge k.
  - topLet_o must not depend combinationally on eta_i1.
- Start-up: before N samples have arrived, the empty slots hold 0 from reset and are counted as zeros. The divisor stays N; there is no partial-window normalisation.
- Boundaries:
  - Full-scale positive (all +2^(SAMPLE_W-1)-1) gives the same value out.
  - Full-scale negative (all -2^(SAMPLE_W-1)) gives the same value out.
  - There is no saturation logic, because none is needed.
- Reset mid-stream clears the whole window; the following samples restart from a zero-filled window.
- Input X/undriven: no checking. X may propagate to the output for up to N cycles after valid data resumes.

Decomposition:
- Shared package ma_pkg:
  - SAMPLE_W and LOG2_N defaults.
  - sample_t, a signed [SAMPLE_W-1:0] typedef.
  - sum_t, a signed [SAMPLE_W+LOG2_N-1:0] typedef.
- One sub-module, ma_window:
  - Parameterised N-deep signed shift register with async active-low clear.
  - Exposes all taps.
- The top level holds the adder tree and the shift.

Test Plan (N=4, SAMPLE_W=8):
- Reset hold with eta_i1 = 55 and clock running -> topLet_o stays 0 throughout reset.
- After reset, feed 4,4,4,4 on consecutive edges -> topLet_o after each edge = 1,2,3,4. Then feed 0,0,0,0 -> 3,2,1,0.
- Feed 127 ×4 -> 31,63,95,127. Feed -128 ×4 -> -32,-64,-96,-128. Neither case may wrap.
- From a zeroed window, feed -1 -> topLet_o = -1 (floor rounding); the next three 0 inputs -> -1,-1,-1; the fourth 0 -> 0.
- Feed 10,-10,10,-10 repeatedly -> once the window is full, topLet_o = 0 every cycle.
- Feed 100 ×4 (out = 100), assert system1000_rstn low mid-cycle -> topLet_o = 0 before the next edge. Release and feed 8 -> 2.
